// File: rtl/apb_gpio_slave.sv
// APB3 slave front-end for GPIO_register: converts APB transfers into a
// single-cycle register strobe, decodes error responses and re-times the interrupt.
module apb_gpio_slave #(
    parameter logic [31:0] ADDR_LAST = 32'h24,
    parameter int          RD_WAIT   = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        gpio_we,
    output logic [31:0] gpio_addr,
    output logic [31:0] gpio_dat_i,
    input  logic [31:0] gpio_dat_o,
    input  logic        gpio_inta_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] prdata_q, prdata_d;
    logic [31:0] gpio_addr_q, gpio_addr_d;
    logic [31:0] gpio_dat_i_q, gpio_dat_i_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic        gpio_we_q, gpio_we_d;
    logic        irq_meta_q, irq_meta_d;
    logic        irq_q, irq_d;

    logic        setup;
    logic        addr_err;

    assign setup    = psel & ~penable;
    // RGPIO_IN at offset 0x00 is read-only, so a write there is an error.
    assign addr_err = (paddr > ADDR_LAST) | (paddr[1:0] != 2'b00) |
                      (pwrite & (paddr == 32'h0));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prdata_d     = prdata_q;
        gpio_addr_d  = gpio_addr_q;
        gpio_dat_i_d = gpio_dat_i_q;
        pready_d     = 1'b0;
        pslverr_d    = 1'b0;
        gpio_we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (setup) begin
                    gpio_addr_d = paddr;
                    if (pwrite) begin
                        gpio_dat_i_d = pwdata;
                    end
                    if (addr_err) begin
                        state_d   = DONE;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = 32'h0;
                    end else if (pwrite) begin
                        state_d   = WRITE;
                        gpio_we_d = 1'b1;
                        pready_d  = 1'b1;
                    end else begin
                        state_d = READ;
                        cnt_d   = 3'(RD_WAIT);
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ: begin
                // Abort takes priority so a dropped psel never sees pready.
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q <= 3'd1) begin
                    state_d  = IDLE;
                    cnt_d    = 3'd0;
                    prdata_d = gpio_dat_o;
                    pready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            prdata_q     <= 32'h0;
            gpio_addr_q  <= 32'h0;
            gpio_dat_i_q <= 32'h0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            gpio_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prdata_q     <= prdata_d;
            gpio_addr_q  <= gpio_addr_d;
            gpio_dat_i_q <= gpio_dat_i_d;
            pready_q     <= pready_d;
            pslverr_q    <= pslverr_d;
            gpio_we_q    <= gpio_we_d;
        end
    end

    always_comb begin
        irq_meta_d = gpio_inta_o;
        irq_d      = irq_meta_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            irq_meta_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_meta_q <= irq_meta_d;
            irq_q      <= irq_d;
        end
    end

    assign prdata     = prdata_q;
    assign pready     = pready_q;
    assign pslverr    = pslverr_q;
    assign gpio_we    = gpio_we_q;
    assign gpio_addr  = gpio_addr_q;
    assign gpio_dat_i = gpio_dat_i_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Scoreboard bench for apb_gpio_slave: the driver queues expected responses,
// a negedge monitor pops them whenever pready or gpio_we is presented.
module tb_apb_gpio_slave;

    localparam int RD_WAIT = 1;

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        gpio_we;
    logic [31:0] gpio_addr;
    logic [31:0] gpio_dat_i;
    logic [31:0] gpio_dat_o;
    logic        gpio_inta_o = 1'b0;
    logic        irq_o;

    logic [31:0] stub_addr = 32'h0;
    logic [31:0] stub_rdata = 32'h0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    resp_t resp_q[$];
    wr_t   wr_q[$];

    apb_gpio_slave #(
        .ADDR_LAST (32'h24),
        .RD_WAIT   (RD_WAIT)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .gpio_we     (gpio_we),
        .gpio_addr   (gpio_addr),
        .gpio_dat_i  (gpio_dat_i),
        .gpio_dat_o  (gpio_dat_o),
        .gpio_inta_o (gpio_inta_o),
        .irq_o       (irq_o)
    );

    // Register-file stub: only answers with the planted value at the expected offset.
    assign gpio_dat_o = (gpio_addr == stub_addr) ? stub_rdata : 32'hDEAD_0000;

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // For reads, data is the value the stub returns at addr.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic exp_err);
        resp_t r;
        wr_t   w;
        bit    seen;
        @(negedge sys_clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        if (!wr) begin
            stub_addr  = addr;
            stub_rdata = data;
        end
        r.err    = exp_err;
        r.chk_rd = !wr || exp_err;
        r.rdata  = exp_err ? 32'h0 : data;
        r.cyc    = cyc + 1 + ((exp_err || wr) ? 0 : RD_WAIT);
        resp_q.push_back(r);
        if (wr && !exp_err) begin
            w.addr = addr;
            w.data = data;
            w.cyc  = cyc + 1;
            wr_q.push_back(w);
        end
        @(negedge sys_clk);
        penable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pready) begin
                seen = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL pready_timeout: addr 0x%08h got no pready, expected one within 20 cycles", addr);
        end
    endtask

    task automatic idleBus();
        @(negedge sys_clk);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    always @(negedge sys_clk) begin : monitor
        resp_t r;
        wr_t   w;
        if (pready) begin
            if (resp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL stray_pready: got pready=1 at cycle %0d, expected 0", cyc);
            end else begin
                r = resp_q.pop_front();
                checkOutput("pready_cycle", 32'(cyc), 32'(r.cyc));
                checkOutput("pslverr", {31'h0, pslverr}, {31'h0, r.err});
                if (r.chk_rd) begin
                    checkOutput("prdata", prdata, r.rdata);
                end
            end
        end
        if (gpio_we) begin
            if (wr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL stray_gpio_we: got gpio_we=1 at cycle %0d, expected 0", cyc);
            end else begin
                w = wr_q.pop_front();
                checkOutput("gpio_we_cycle", 32'(cyc), 32'(w.cyc));
                checkOutput("gpio_addr", gpio_addr, w.addr);
                checkOutput("gpio_dat_i", gpio_dat_i, w.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        checkOutput("reset_pready", {31'h0, pready}, 32'h0);
        checkOutput("reset_pslverr", {31'h0, pslverr}, 32'h0);
        checkOutput("reset_gpio_we", {31'h0, gpio_we}, 32'h0);
        checkOutput("reset_prdata", prdata, 32'h0);
        checkOutput("reset_gpio_addr", gpio_addr, 32'h0);
        checkOutput("reset_gpio_dat_i", gpio_dat_i, 32'h0);
        checkOutput("reset_irq_o", {31'h0, irq_o}, 32'h0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);

        applyStimulus(1'b1, 32'h04, 32'hAAAA_AAAA, 1'b0);
        idleBus();
        applyStimulus(1'b0, 32'h08, 32'hFFFF_FFFF, 1'b0);
        idleBus();
        applyStimulus(1'b0, 32'h28, 32'h1357_9BDF, 1'b1);
        idleBus();
        applyStimulus(1'b1, 32'h06, 32'h0000_00FF, 1'b1);
        idleBus();
        applyStimulus(1'b1, 32'h00, 32'h0000_0001, 1'b1);
        idleBus();
        applyStimulus(1'b1, 32'h0C, 32'h0000_0001, 1'b0);
        applyStimulus(1'b1, 32'h10, 32'h0000_0001, 1'b0);
        applyStimulus(1'b0, 32'h24, 32'h1234_5678, 1'b0);
        applyStimulus(1'b1, 32'h24, 32'h5A5A_0001, 1'b0);
        idleBus();
        applyStimulus(1'b0, 32'h00, 32'hCAFE_0000, 1'b0);
        applyStimulus(1'b0, 32'h25, 32'h2468_ACE0, 1'b1);
        applyStimulus(1'b0, 32'hFFFF_FF24, 32'h3333_3333, 1'b1);
        applyStimulus(1'b0, 32'h14, 32'h0BAD_F00D, 1'b0);
        idleBus();

        // Access phase with no preceding setup phase must be ignored.
        @(negedge sys_clk);
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        pwdata  = 32'h9999_9999;
        repeat (3) begin
            @(negedge sys_clk);
            checkOutput("ignored_access_pready", {31'h0, pready}, 32'h0);
            checkOutput("ignored_access_gpio_we", {31'h0, gpio_we}, 32'h0);
        end
        idleBus();

        // Master drops psel while the read is still waiting.
        @(negedge sys_clk);
        psel       = 1'b1;
        penable    = 1'b0;
        pwrite     = 1'b0;
        paddr      = 32'h18;
        stub_addr  = 32'h18;
        stub_rdata = 32'h1111_1111;
        @(negedge sys_clk);
        psel = 1'b0;
        repeat (3) @(negedge sys_clk);
        checkOutput("abort_prdata_hold", prdata, 32'h0BAD_F00D);

        gpio_inta_o = 1'b1;
        repeat (3) @(negedge sys_clk);
        checkOutput("irq_pre_reset", {31'h0, irq_o}, 32'h1);

        // Reset asserted while a read is in its wait cycle.
        @(negedge sys_clk);
        psel       = 1'b1;
        penable    = 1'b0;
        pwrite     = 1'b0;
        paddr      = 32'h1C;
        stub_addr  = 32'h1C;
        stub_rdata = 32'h2222_2222;
        @(negedge sys_clk);
        penable = 1'b1;
        #1;
        sys_rst     = 1'b0;
        gpio_inta_o = 1'b0;
        #1;
        checkOutput("midreset_pready", {31'h0, pready}, 32'h0);
        checkOutput("midreset_pslverr", {31'h0, pslverr}, 32'h0);
        checkOutput("midreset_gpio_we", {31'h0, gpio_we}, 32'h0);
        checkOutput("midreset_prdata", prdata, 32'h0);
        checkOutput("midreset_gpio_addr", gpio_addr, 32'h0);
        checkOutput("midreset_gpio_dat_i", gpio_dat_i, 32'h0);
        checkOutput("midreset_irq_o", {31'h0, irq_o}, 32'h0);
        @(negedge sys_clk);
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (5) begin
            @(negedge sys_clk);
            checkOutput("post_reset_pready", {31'h0, pready}, 32'h0);
        end

        @(negedge sys_clk);
        gpio_inta_o = 1'b1;
        @(negedge sys_clk);
        checkOutput("irq_rise_one_edge", {31'h0, irq_o}, 32'h0);
        @(negedge sys_clk);
        checkOutput("irq_rise_two_edges", {31'h0, irq_o}, 32'h1);
        gpio_inta_o = 1'b0;
        @(negedge sys_clk);
        checkOutput("irq_fall_one_edge", {31'h0, irq_o}, 32'h1);
        @(negedge sys_clk);
        checkOutput("irq_fall_two_edges", {31'h0, irq_o}, 32'h0);

        applyStimulus(1'b1, 32'h20, 32'h0000_0077, 1'b0);
        idleBus();
        repeat (4) @(negedge sys_clk);
        checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'h0);
        checkOutput("write_queue_drained", 32'(wr_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
